vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5: system clocks per pixel (125 MHz to 25 MHz).
REQ-002 SHALL have parameter H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48: horizontal timing in pixels.
REQ-003 SHALL have parameter V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33: vertical timing in lines.
REQ-004 SHALL have port clk, input, 1: system clock; all logic rising-edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port rgb_in, input, 12: client pixel colour {r,g,b} for the current pix_x/pix_y.
REQ-007 SHALL have port pix_x, output, 10: current horizontal counter.
REQ-008 SHALL have port pix_y, output, 10: current vertical counter.
REQ-009 SHALL have port pix_active, output, 1: high when pix_x<H_ACTIVE and pix_y<V_ACTIVE.
REQ-010 SHALL have port pix_en, output, 1: one-clk strobe marking each pixel tick.
REQ-011 SHALL have port frame_start, output, 1: one-clk strobe on the tick that wraps counters to (0,0).
REQ-012 SHALL have ports r, g, b, output, 4 each: registered colour to the pin mapper.
REQ-013 SHALL have ports hs and vs, output, 1 each: registered active-low syncs.

Function
REQ-014 Prescaler SHALL count 0..CLK_DIV-1 and wrap; pix_en SHALL be high when prescaler==CLK_DIV-1.
REQ-015 On pix_en, pix_x SHALL increment; at H_TOTAL-1 (799) it SHALL wrap to 0 and pix_y SHALL increment.
REQ-016 pix_y SHALL wrap from V_TOTAL-1 (524) to 0 only on the same pix_en as the pix_x wrap.
REQ-017 frame_start SHALL pulse for one clk together with the pix_en where pix_x=799 and pix_y=524.
REQ-018 Counters and outputs SHALL hold between pix_en strobes.
REQ-019 pix_x, pix_y, pix_active SHALL be combinational from counters; the client has one pixel period to drive rgb_in.
REQ-020 On each pix_en, {r,g,b} SHALL register rgb_in if pix_active, else 12'h000.
REQ-021 On each pix_en, hs SHALL register 0 iff 656<=pix_x<=751, else 1.
REQ-022 On each pix_en, vs SHALL register 0 iff 490<=pix_y<=491, else 1.
REQ-023 Output latency SHALL be one pixel period: r/g/b/hs/vs for pixel (x,y) appear after the pix_en ending that pixel.
REQ-024 Sync and blank boundaries SHALL derive from the parameters, not constants; the values above are the defaults.

Reset
REQ-025 While reset_n=0: prescaler, pix_x, pix_y = 0; r,g,b = 0; hs=vs=1; pix_en=frame_start=0.
REQ-026 Reset asserted mid-frame SHALL clear state immediately; after release, timing SHALL restart at (0,0).
REQ-027 The first pix_en SHALL occur on the CLK_DIV-th rising clk edge after reset_n rises.

Configuration
REQ-028 Macro VGA_TEST_PATTERN_EN SHALL select the colour source.
REQ-029 If defined, rgb_in SHALL be ignored and active pixels SHALL show 8 vertical bars 80 px wide, bar index pix_x[9:0]/80: white, yellow, cyan, green, magenta, red, blue, black (4'hF/4'h0 per channel).
REQ-030 If undefined, colour SHALL come from rgb_in per REQ-020, with no pattern logic synthesized.

Verification
REQ-031 Reset release, then count clks -> first pix_en on edge 5; pix_en period exactly 5 clks thereafter.
REQ-032 Run 2 frames -> hs low 96 ticks per line, line period 800 ticks; vs low exactly 2 lines (1600 ticks), frame period 420000 ticks; frame_start once per frame.
REQ-033 rgb_in=12'hABC held -> r=A,g=B,b=C for x<640,y<480; r=g=b=0 during all blanking; first coloured output one tick after (0,0).
REQ-034 Assert reset_n low at pix_x=300, pix_y=200 -> outputs go to reset values asynchronously; after release, pix_x=pix_y=0, frame_start after 420000 ticks.
REQ-035 With VGA_TEST_PATTERN_EN defined -> x=0..79 outputs FFF, x=80 outputs FF0, x=560..639 outputs 000, regardless of rgb_in.
REQ-036 Wrap check -> tick at (799,524) returns (0,0) with frame_start=1; tick at (799,100) gives (0,101).

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel prescaler, h/v counters, registered colour and syncs.
// Define VGA_TEST_PATTERN_EN to replace rgb_in with eight built-in colour bars.
module vga_timing_gen #(
  parameter int CLK_DIV  = 5,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_active,
  output logic        pix_en,
  output logic        frame_start,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC - 1;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] pre;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic          h_last;
  logic          v_last;
  logic [11:0]   colour;
  logic          hs_nxt;
  logic          vs_nxt;

  // Gate with reset_n so pix_en stays low in reset even when CLK_DIV is 1.
  assign pix_en      = reset_n & (pre == PW'(CLK_DIV - 1));
  assign h_last      = (hcnt == 10'(H_TOTAL - 1));
  assign v_last      = (vcnt == 10'(V_TOTAL - 1));
  assign frame_start = pix_en & h_last & v_last;
  assign pix_x       = hcnt;
  assign pix_y       = vcnt;
  assign pix_active  = (hcnt < 10'(H_ACTIVE)) &&
                       (vcnt < 10'(V_ACTIVE));

  assign hs_nxt = !((hcnt >= 10'(HS_BEG)) &&
                    (hcnt <= 10'(HS_END)));
  assign vs_nxt = !((vcnt >= 10'(VS_BEG)) &&
                    (vcnt <= 10'(VS_END)));

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;

  always_comb begin
    bar    = 3'(hcnt / 10'(BAR_W));
    colour = 12'h000;
    unique case (bar)
      3'd0:    colour = 12'hFFF;
      3'd1:    colour = 12'hFF0;
      3'd2:    colour = 12'h0FF;
      3'd3:    colour = 12'h0F0;
      3'd4:    colour = 12'hF0F;
      3'd5:    colour = 12'hF00;
      3'd6:    colour = 12'h00F;
      default: colour = 12'h000;
    endcase
  end
`else
  assign colour = rgb_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (pix_en) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Outputs describe the pixel that just ended: one pixel of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {r, g, b} <= 12'h000;
      hs        <= 1'b1;
      vs        <= 1'b1;
    end else if (pix_en) begin
      {r, g, b} <= pix_active ? colour : 12'h000;
      hs        <= hs_nxt;
      vs        <= vs_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a shrunk-timing instance for whole
// frames plus a default-timing instance for one 800-pixel line.
module tb_vga_timing_gen;

  localparam int DIV = 5;
  localparam int HA  = 16;
  localparam int HF  = 2;
  localparam int HSW = 3;
  localparam int HB  = 3;
  localparam int VA  = 8;
  localparam int VF  = 1;
  localparam int VSW = 2;
  localparam int VB  = 2;
  localparam int HT  = 24;
  localparam int VT  = 13;
  localparam int FT  = 312;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] rgb_in = 12'hABC;

  logic [9:0] pix_x, pix_y;
  logic       pix_active, pix_en, frame_start;
  logic [3:0] r, g, b;
  logic       hs, vs;

  logic [9:0] d_pix_x, d_pix_y;
  logic       d_pix_active, d_pix_en, d_frame_start;
  logic [3:0] d_r, d_g, d_b;
  logic       d_hs, d_vs;

  int n_run  = 0;
  int n_fail = 0;
  int hold_err = 0;

  always #4 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_active(pix_active), .pix_en(pix_en),
    .frame_start(frame_start),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs)
  );

  vga_timing_gen u_def (
    .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in),
    .pix_x(d_pix_x), .pix_y(d_pix_y),
    .pix_active(d_pix_active), .pix_en(d_pix_en),
    .frame_start(d_frame_start),
    .r(d_r), .g(d_g), .b(d_b), .hs(d_hs), .vs(d_vs)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_col(input int x, input int y);
    if (x >= HA || y >= VA) return 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    case (x / (HA / 8))
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
`else
    return rgb_in;
`endif
  endfunction

  // Advance to the negedge just before the next tick; counters must hold meanwhile.
  task automatic next_tick(input bit dflt, output bit ok);
    logic [9:0] x0;
    ok = 1'b0;
    x0 = dflt ? d_pix_x : pix_x;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if ((dflt ? d_pix_x : pix_x) !== x0) hold_err++;
      if (dflt ? d_pix_en : pix_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic goto_xy(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FT * DIV; i++) begin
      @(negedge clk);
      if (pix_x == 10'(x) && pix_y == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits[$];
    int fs_idx[$];
    bit ok, to;
    int px, py, nx, ny;
    logic fs, act;
    logic [11:0] col, first_col, pre_col;
    logic [19:0] mid_xy;
    int hs_low, vs_low, col_err, hs_err, vs_err;
    int wrap_err, fs_err, act_err, n, first_low;
    logic [11:0] c639, c640;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_xy", {pix_x, pix_y}, 20'd0);
    check("rst_rgb", {r, g, b}, 12'h000);
    check("rst_sync", {hs, vs}, 2'b11);
    check("rst_strb", {pix_en, frame_start}, 2'b00);
    check("rst_def", {d_hs, d_vs, d_r, d_pix_en}, 7'b1100000);

    // First strobe on edge 5, then every 5 clks.
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (pix_en) hits.push_back(k);
      @(negedge clk);
      #1;
    end
    check("first_en", hits.size() > 0 ? hits[0] : 0, 5);
    check("en_per1", hits.size() > 1 ? hits[1] - hits[0] : 0, DIV);
    check("en_per2", hits.size() > 2 ? hits[2] - hits[1] : 0, DIV);
    check("ticks_x", pix_x, 10'd3);

    // Two full frames from (0,0).
    do_reset();
    to = 0;
    hs_low = 0; vs_low = 0; col_err = 0; hs_err = 0; vs_err = 0;
    wrap_err = 0; fs_err = 0; act_err = 0;
    first_col = '0; mid_xy = '1;
    for (int t = 0; t < 2 * FT; t++) begin
      next_tick(1'b0, ok);
      if (!ok) begin
        to = 1;
        break;
      end
      px = int'(pix_x); py = int'(pix_y);
      fs = frame_start; act = pix_active;
      col = exp_col(px, py);
      if (act !== (px < HA && py < VA)) act_err++;
      if (fs !== (px == 23 && py == 12)) fs_err++;
      if (fs) fs_idx.push_back(t);
      @(posedge clk);
      #1;
      if (t == 0) first_col = {r, g, b};
      if ({r, g, b} !== col) col_err++;
      if (hs !== !(px >= 18 && px <= 20)) hs_err++;
      if (vs !== !(py >= 9 && py <= 10)) vs_err++;
      hs_low += int'(!hs);
      vs_low += int'(!vs);
      nx = (px == 23) ? 0 : px + 1;
      ny = (px != 23) ? py : (py == 12) ? 0 : py + 1;
      if ({pix_x, pix_y} !== {10'(nx), 10'(ny)}) wrap_err++;
      if (px == 23 && py == 5) mid_xy = {pix_x, pix_y};
    end
    check("frm_timeout", to, 0);
    check("hs_low", hs_low, 2 * VT * HSW);
    check("vs_low", vs_low, 2 * VSW * HT);
    check("fs_count", fs_idx.size(), 2);
    check("fs_first", fs_idx.size() > 0 ? fs_idx[0] : -1, FT - 1);
    check("fs_period", fs_idx.size() > 1 ? fs_idx[1] - fs_idx[0] : 0, FT);
    check("first_col", first_col, exp_col(0, 0));
    check("col_err", col_err, 0);
    check("hs_err", hs_err, 0);
    check("vs_err", vs_err, 0);
    check("wrap_err", wrap_err, 0);
    check("wrap_mid", mid_xy, {10'd0, 10'd6});
    check("fs_err", fs_err, 0);
    check("act_err", act_err, 0);
    check("hold_err", hold_err, 0);

    // Mid-frame reset while colour is showing.
    do_reset();
    goto_xy(5, 3, ok);
    check("goto_53", ok, 1);
    pre_col = {r, g, b};
    check("pre_col", pre_col, exp_col(4, 3));
    #1 reset_n = 1'b0;
    #1;
    check("arst_rgb", {r, g, b}, 12'h000);
    check("arst_xy", {pix_x, pix_y}, 20'd0);

    // Mid-frame reset inside both sync pulses.
    do_reset();
    goto_xy(19, 9, ok);
    check("goto_199", ok, 1);
    check("pre_sync", {hs, vs}, 2'b00);
    #1 reset_n = 1'b0;
    #1;
    check("arst_sync", {hs, vs}, 2'b11);
    check("arst_en", pix_en, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_xy", {pix_x, pix_y}, 20'd0);
    n = -1;
    for (int t = 0; t < 2 * FT; t++) begin
      next_tick(1'b0, ok);
      if (!ok) break;
      if (frame_start) begin
        n = t;
        break;
      end
      @(posedge clk);
    end
    check("rel_fs", n, FT - 1);

    // Default timing: one full 800-pixel line.
    do_reset();
    hs_low = 0; vs_low = 0; first_low = -1; to = 0;
    c639 = '1; c640 = '1;
    for (int t = 0; t < 800; t++) begin
      next_tick(1'b1, ok);
      if (!ok) begin
        to = 1;
        break;
      end
      @(posedge clk);
      #1;
      if (!d_hs) begin
        hs_low++;
        if (first_low < 0) first_low = t;
      end
      vs_low += int'(!d_vs);
      if (t == 639) c639 = {d_r, d_g, d_b};
      if (t == 640) c640 = {d_r, d_g, d_b};
    end
    check("d_timeout", to, 0);
    check("d_hs_low", hs_low, 96);
    check("d_hs_first", first_low, 656);
    check("d_vs_low", vs_low, 0);
    check("d_wrap", {d_pix_x, d_pix_y}, {10'd0, 10'd1});
    check("d_c639", c639, exp_col(0, 0) == 12'h000 ? 12'h000 :
`ifdef VGA_TEST_PATTERN_EN
          12'h000);
`else
          12'hABC);
`endif
    check("d_c640", c640, 12'h000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
